// File: rtl/bot_arena_pkg.sv
// Shared types and constants for the bot arena: run states, motor/sensor
// direction indices and default arena geometry.
package bot_arena_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } arenaState_t;

   localparam int UP    = 0;
   localparam int RIGHT = 1;
   localparam int DOWN  = 2;
   localparam int LEFT  = 3;

   localparam int DEF_COORD_W = 4;
   localparam int DEF_GRID_W  = 16;
   localparam int DEF_GRID_H  = 16;

endpackage

// File: rtl/bot_axis_step.sv
// One-axis position update: steps by +1/-1 from the motor pair, holding and
// flagging blocked when the result would leave [0, limit].
module bot_axis_step
   import bot_arena_pkg::*;
#(
   parameter int COORD_W = DEF_COORD_W
) (
   input  logic [COORD_W-1:0] pos,
   input  logic               plus,
   input  logic               minus,
   input  logic [COORD_W:0]   limit,
   output logic [COORD_W-1:0] next_pos,
   output logic               blocked
);

   localparam logic [COORD_W:0]   ONE_W = 1;
   localparam logic [COORD_W-1:0] ONE   = 1;

   logic [COORD_W:0] posWide;
   logic [COORD_W:0] posInc;

   // One extra bit so the upper bound check can never wrap.
   assign posWide = {1'b0, pos};
   assign posInc  = posWide + ONE_W;

   always_comb begin
      next_pos = pos;
      blocked  = 1'b0;
      if (plus && !minus) begin
         if (posInc > limit) blocked = 1'b1;
         else                next_pos = posInc[COORD_W-1:0];
      end else if (minus && !plus) begin
         if (posWide == '0) blocked = 1'b1;
         else               next_pos = pos - ONE;
      end
   end

endmodule

// File: rtl/bot_position_tracker.sv
// Arena model closing the loop around a scoot bot: integrates motor commands
// into a grid position and feeds back light-direction sensors.
//
//   state | meaning
//   IDLE  | waiting for start after reset
//   RUN   | integrating motor commands, sensors live
//   DONE  | run ended (found light or step budget spent); start re-arms
module bot_position_tracker
   import bot_arena_pkg::*;
#(
   parameter int COORD_W   = DEF_COORD_W,
   parameter int GRID_W    = DEF_GRID_W,
   parameter int GRID_H    = DEF_GRID_H,
   parameter int START_X   = 0,
   parameter int START_Y   = 0,
   parameter int STEP_W    = 8,
   parameter int MAX_STEPS = 200
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [COORD_W-1:0] lightX,
   input  logic [COORD_W-1:0] lightY,
   input  logic               mUp,
   input  logic               mRight,
   input  logic               mDown,
   input  logic               mLeft,
   output logic               lUp,
   output logic               lRight,
   output logic               lDown,
   output logic               lLeft,
   output logic [COORD_W-1:0] posX,
   output logic [COORD_W-1:0] posY,
   output logic [STEP_W-1:0]  steps,
   output logic               running,
   output logic               done,
   output logic               found,
   output logic               wallHit
);

   localparam logic [COORD_W:0]   X_LIM     = (COORD_W+1)'(GRID_W - 1);
   localparam logic [COORD_W:0]   Y_LIM     = (COORD_W+1)'(GRID_H - 1);
   localparam logic [COORD_W-1:0] START_XC  = COORD_W'(START_X);
   localparam logic [COORD_W-1:0] START_YC  = COORD_W'(START_Y);
   localparam logic [STEP_W-1:0]  STEPS_MAX = STEP_W'(MAX_STEPS);
   localparam logic [STEP_W-1:0]  STEP_ONE  = 1;

   arenaState_t        state;
   logic [COORD_W-1:0] lightXr;
   logic [COORD_W-1:0] lightYr;
   logic [COORD_W-1:0] lightXClamp;
   logic [COORD_W-1:0] lightYClamp;
   logic [COORD_W-1:0] nextX;
   logic [COORD_W-1:0] nextY;
   logic               blockX;
   logic               blockY;
   logic [3:0]         motor;
   logic               atLight;
   logic               inRun;

   assign motor = {mLeft, mDown, mRight, mUp};

   assign lightXClamp = ({1'b0, lightX} > X_LIM) ? X_LIM[COORD_W-1:0] : lightX;
   assign lightYClamp = ({1'b0, lightY} > Y_LIM) ? Y_LIM[COORD_W-1:0] : lightY;

   bot_axis_step #(.COORD_W(COORD_W)) uStepX (
      .pos      (posX),
      .plus     (motor[RIGHT]),
      .minus    (motor[LEFT]),
      .limit    (X_LIM),
      .next_pos (nextX),
      .blocked  (blockX)
   );

   bot_axis_step #(.COORD_W(COORD_W)) uStepY (
      .pos      (posY),
      .plus     (motor[UP]),
      .minus    (motor[DOWN]),
      .limit    (Y_LIM),
      .next_pos (nextY),
      .blocked  (blockY)
   );

   // Sensors come only from registers, so the bot sees no combinational path.
   assign inRun   = (state == RUN);
   assign atLight = (posX == lightXr) && (posY == lightYr);
   assign lUp     = inRun && (lightYr > posY);
   assign lDown   = inRun && (lightYr < posY);
   assign lRight  = inRun && (lightXr > posX);
   assign lLeft   = inRun && (lightXr < posX);
   assign running = inRun;
   assign done    = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         posX    <= START_XC;
         posY    <= START_YC;
         steps   <= '0;
         found   <= 1'b0;
         wallHit <= 1'b0;
         lightXr <= '0;
         lightYr <= '0;
      end else begin
         wallHit <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state   <= RUN;
                  posX    <= START_XC;
                  posY    <= START_YC;
                  steps   <= '0;
                  found   <= 1'b0;
                  lightXr <= lightXClamp;
                  lightYr <= lightYClamp;
               end
            end
            RUN: begin
               if (atLight) begin
                  state <= DONE;
                  found <= 1'b1;
               end else if (steps == STEPS_MAX) begin
                  state <= DONE;
                  found <= 1'b0;
               end else begin
                  posX    <= nextX;
                  posY    <= nextY;
                  steps   <= steps + STEP_ONE;
                  wallHit <= blockX || blockY;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bot_position_tracker.sv
// Scoreboarded bench: two tracker builds (16x16 default, and a 10-wide grid
// with START_X=7 and a 4-step budget) driven by directed motor vectors.
module tb_bot_position_tracker;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] lightX, lightY;
   logic       mUp, mRight, mDown, mLeft;

   logic [3:0] pxA, pyA, pxB, pyB, sensA, sensB;
   logic [7:0] stA, stB;
   logic       runA, doneA, foundA, wallA;
   logic       runB, doneB, foundB, wallB;

   typedef struct {
      bit          sel;
      string       nm;
      logic [23:0] v;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   bot_position_tracker dutA (
      .clk(clk), .rst_n(rst_n), .start(start), .lightX(lightX), .lightY(lightY),
      .mUp(mUp), .mRight(mRight), .mDown(mDown), .mLeft(mLeft),
      .lUp(sensA[3]), .lRight(sensA[2]), .lDown(sensA[1]), .lLeft(sensA[0]),
      .posX(pxA), .posY(pyA), .steps(stA), .running(runA), .done(doneA),
      .found(foundA), .wallHit(wallA)
   );

   bot_position_tracker #(.GRID_W(10), .START_X(7), .MAX_STEPS(4)) dutB (
      .clk(clk), .rst_n(rst_n), .start(start), .lightX(lightX), .lightY(lightY),
      .mUp(mUp), .mRight(mRight), .mDown(mDown), .mLeft(mLeft),
      .lUp(sensB[3]), .lRight(sensB[2]), .lDown(sensB[1]), .lLeft(sensB[0]),
      .posX(pxB), .posY(pyB), .steps(stB), .running(runB), .done(doneB),
      .found(foundB), .wallHit(wallB)
   );

   // Snapshot layout: posX, posY, steps, running, done, found, wallHit, {lUp,lRight,lDown,lLeft}
   function automatic logic [23:0] snap(input bit sel);
      if (sel) return {pxB, pyB, stB, runB, doneB, foundB, wallB, sensB};
      return {pxA, pyA, stA, runA, doneA, foundA, wallA, sensA};
   endfunction

   function automatic logic [23:0] ex(input int x, input int y, input int s,
                                      input bit r, input bit d, input bit f,
                                      input bit w, input logic [3:0] sn);
      return {4'(x), 4'(y), 8'(s), r, d, f, w, sn};
   endfunction

   task automatic check(input string nm, input logic [23:0] act, input logic [23:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   task automatic cyc(input bit sel, input string nm, input logic st,
                      input logic [3:0] lx, input logic [3:0] ly,
                      input logic [3:0] mot, input logic [23:0] expv);
      @(negedge clk);
      start  = st;
      lightX = lx;
      lightY = ly;
      {mUp, mRight, mDown, mLeft} = mot;
      sb.push_back('{sel, nm, expv});
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.nm, snap(e.sel), e.v);
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      rst_n = 1'b0; start = 1'b0; lightX = '0; lightY = '0;
      {mUp, mRight, mDown, mLeft} = 4'b0000;
      @(negedge clk); @(negedge clk);
      check("reset_A", snap(0), ex(0, 0, 0, 0, 0, 0, 0, 4'b0000));
      check("reset_B", snap(1), ex(7, 0, 0, 0, 0, 0, 0, 4'b0000));
      rst_n = 1'b1;

      // reset in the middle of a run
      cyc(0, "mid_start", 1, 8, 8, 4'b0000, ex(0, 0, 0, 1, 0, 0, 0, 4'b1100));
      for (int k = 1; k <= 5; k++)
         cyc(0, "mid_right", 0, 8, 8, 4'b0100, ex(k, 0, k, 1, 0, 0, 0, 4'b1100));
      @(negedge clk);
      rst_n = 1'b0;
      {mUp, mRight, mDown, mLeft} = 4'b0000;
      #1;
      check("mid_async_reset", snap(0), ex(0, 0, 0, 0, 0, 0, 0, 4'b0000));
      @(negedge clk);
      rst_n = 1'b1;

      // direct seek to (3,2) with motors mirroring sensors
      cyc(0, "seek_start", 1, 3, 2, 4'b0000, ex(0, 0, 0, 1, 0, 0, 0, 4'b1100));
      cyc(0, "seek_1", 0, 3, 2, 4'b1100, ex(1, 1, 1, 1, 0, 0, 0, 4'b1100));
      cyc(0, "seek_2", 0, 3, 2, 4'b1100, ex(2, 2, 2, 1, 0, 0, 0, 4'b0100));
      cyc(0, "seek_3", 0, 3, 2, 4'b0100, ex(3, 2, 3, 1, 0, 0, 0, 4'b0000));
      cyc(0, "seek_done", 0, 3, 2, 4'b0000, ex(3, 2, 3, 0, 1, 1, 0, 4'b0000));

      // start position equal to the light
      cyc(0, "atlight_start", 1, 0, 0, 4'b0000, ex(0, 0, 0, 1, 0, 0, 0, 4'b0000));
      cyc(0, "atlight_done", 0, 0, 0, 4'b0100, ex(0, 0, 0, 0, 1, 1, 0, 4'b0000));
      cyc(0, "done_ignores_motors", 0, 0, 0, 4'b1111, ex(0, 0, 0, 0, 1, 1, 0, 4'b0000));

      // cancellation and walls
      cyc(0, "wall_start", 1, 8, 8, 4'b0000, ex(0, 0, 0, 1, 0, 0, 0, 4'b1100));
      cyc(0, "left_wall", 0, 8, 8, 4'b0001, ex(0, 0, 1, 1, 0, 0, 1, 4'b1100));
      cyc(0, "updown_cancel", 0, 8, 8, 4'b1010, ex(0, 0, 2, 1, 0, 0, 0, 4'b1100));
      for (int x = 1; x <= 15; x++)
         cyc(0, "walk_right", 0, 8, 8, 4'b0100,
             ex(x, 0, 2 + x, 1, 0, 0, 0, (x < 8) ? 4'b1100 : (x == 8) ? 4'b1000 : 4'b1001));
      cyc(0, "right_wall", 0, 8, 8, 4'b0100, ex(15, 0, 18, 1, 0, 0, 1, 4'b1001));
      cyc(0, "updown_cancel_15", 0, 8, 8, 4'b1010, ex(15, 0, 19, 1, 0, 0, 0, 4'b1001));
      cyc(0, "leftright_cancel", 0, 8, 8, 4'b0101, ex(15, 0, 20, 1, 0, 0, 0, 4'b1001));
      cyc(0, "diag_half_block", 0, 8, 8, 4'b1100, ex(15, 1, 21, 1, 0, 0, 1, 4'b1001));
      cyc(0, "down_move", 0, 8, 8, 4'b0010, ex(15, 0, 22, 1, 0, 0, 0, 4'b1001));
      cyc(0, "bottom_wall", 0, 8, 8, 4'b0010, ex(15, 0, 23, 1, 0, 0, 1, 4'b1001));

      @(negedge clk);
      rst_n = 1'b0;
      start = 1'b0;
      {mUp, mRight, mDown, mLeft} = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;

      // timeout on the 4-step build
      cyc(1, "to_start", 1, 8, 8, 4'b0000, ex(7, 0, 0, 1, 0, 0, 0, 4'b1100));
      for (int k = 1; k <= 4; k++)
         cyc(1, "to_idle_step", 0, 8, 8, 4'b0000, ex(7, 0, k, 1, 0, 0, 0, 4'b1100));
      cyc(1, "to_done", 0, 8, 8, 4'b0000, ex(7, 0, 4, 0, 1, 0, 0, 4'b0000));

      // restart from DONE with lightX clamped 15 -> 9; start during RUN ignored
      cyc(1, "clamp_start", 1, 15, 0, 4'b0000, ex(7, 0, 0, 1, 0, 0, 0, 4'b0100));
      cyc(1, "run_start_ignored", 1, 7, 0, 4'b0100, ex(8, 0, 1, 1, 0, 0, 0, 4'b0100));
      cyc(1, "clamp_reach", 0, 7, 0, 4'b0100, ex(9, 0, 2, 1, 0, 0, 0, 4'b0000));
      cyc(1, "clamp_found", 0, 7, 0, 4'b0100, ex(9, 0, 2, 0, 1, 1, 0, 4'b0000));
      cyc(1, "rearm_held", 1, 8, 8, 4'b0000, ex(7, 0, 0, 1, 0, 0, 0, 4'b1100));
      cyc(1, "held_in_run", 1, 8, 8, 4'b0000, ex(7, 0, 1, 1, 0, 0, 0, 4'b1100));

      @(posedge clk);
      #3;
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
